// File: rtl/issue_queue_multi.sv
// In-order issue queue: multi-lane enqueue, oldest OUT_WIDTH entries presented to issue,
// with result-bus snooping on both stored and incoming operands.
module issue_queue_multi #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned IN_WIDTH  = 4,
  parameter int unsigned OUT_WIDTH = 2,
  parameter int unsigned FWD_PORTS = 4,
  parameter int unsigned OP_W      = 4,
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned DATA_W    = 16,
  localparam int unsigned PAY_W    = OP_W + 3*TAG_W + 2*DATA_W + 2,
  localparam int unsigned ENTRY_W  = PAY_W + 1,
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1),
  localparam int unsigned DQ_W     = $clog2(OUT_WIDTH + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [IN_WIDTH-1:0]            in_valid,
  input  logic [IN_WIDTH*PAY_W-1:0]      in_entry,
  output logic                           in_ready,
  input  logic [FWD_PORTS-1:0]           fwd_valid,
  input  logic [FWD_PORTS*TAG_W-1:0]     fwd_tag,
  input  logic [FWD_PORTS*DATA_W-1:0]    fwd_data,
  output logic [OUT_WIDTH*ENTRY_W-1:0]   out_entry,
  output logic [OUT_WIDTH-1:0]           out_ready,
  input  logic [DQ_W-1:0]                deq_count,
  output logic [CNT_W-1:0]               count
);

  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned PEND_B   = 0;
  localparam int unsigned PEND_A   = 1;
  localparam int unsigned VALB_LSB = 2;
  localparam int unsigned VALA_LSB = 2 + DATA_W;
  localparam int unsigned TAGB_LSB = 2 + 2*DATA_W;
  localparam int unsigned TAGA_LSB = TAGB_LSB + TAG_W;

  // Capture matching results into pending operands; lowest-index bus wins.
  function automatic logic [PAY_W-1:0] fwd_resolve(
    input logic [PAY_W-1:0]           p,
    input logic [FWD_PORTS-1:0]       v,
    input logic [FWD_PORTS*TAG_W-1:0] t,
    input logic [FWD_PORTS*DATA_W-1:0] d
  );
    logic [PAY_W-1:0] r;
    logic             hit_a;
    logic             hit_b;
    r     = p;
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int q = 0; q < FWD_PORTS; q++) begin
      if (!hit_a && p[PEND_A] && v[q] && (p[TAGA_LSB +: TAG_W] == t[q*TAG_W +: TAG_W])) begin
        r[VALA_LSB +: DATA_W] = d[q*DATA_W +: DATA_W];
        r[PEND_A]             = 1'b0;
        hit_a                 = 1'b1;
      end
      if (!hit_b && p[PEND_B] && v[q] && (p[TAGB_LSB +: TAG_W] == t[q*TAG_W +: TAG_W])) begin
        r[VALB_LSB +: DATA_W] = d[q*DATA_W +: DATA_W];
        r[PEND_B]             = 1'b0;
        hit_b                 = 1'b1;
      end
    end
    return r;
  endfunction

  logic [PAY_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic [CNT_W-1:0] w_n_in;
  logic [CNT_W-1:0] w_n_acc;
  logic [CNT_W-1:0] w_lanes;
  logic [CNT_W-1:0] w_deq;
  logic [PAY_W-1:0] w_in_res   [IN_WIDTH];
  logic [PTR_W-1:0] w_enq_off  [DEPTH];
  logic [PTR_W-1:0] w_deq_off  [DEPTH];
  logic [PAY_W-1:0] w_enq_data [DEPTH];
  logic [PAY_W-1:0] w_mem_res  [DEPTH];
  logic [DEPTH-1:0] w_enq_hit;
  logic [DEPTH-1:0] w_deq_hit;
  logic [PTR_W-1:0] w_out_idx  [OUT_WIDTH];
  logic [OUT_WIDTH-1:0] w_out_vld;

  assign in_ready = (r_count <= CNT_W'(DEPTH - IN_WIDTH));
  assign count    = r_count;

  // Accepted enqueue count and clamped dequeue count.
  always_comb begin
    w_n_in = '0;
    for (int k = 0; k < IN_WIDTH; k++) begin
      w_n_in = w_n_in + CNT_W'(in_valid[k]);
    end
    w_n_acc = in_ready ? w_n_in : '0;
    w_lanes = (r_count < CNT_W'(OUT_WIDTH)) ? r_count : CNT_W'(OUT_WIDTH);
    w_deq   = (CNT_W'(deq_count) < w_lanes) ? CNT_W'(deq_count) : w_lanes;
  end

  // Per-entry enqueue/dequeue selection and forwarded next payloads.
  always_comb begin
    for (int k = 0; k < IN_WIDTH; k++) begin
      w_in_res[k] = fwd_resolve(in_entry[k*PAY_W +: PAY_W], fwd_valid, fwd_tag, fwd_data);
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_enq_off[i]  = PTR_W'(PTR_W'(i) - r_tail);
      w_deq_off[i]  = PTR_W'(PTR_W'(i) - r_head);
      w_enq_hit[i]  = (CNT_W'(w_enq_off[i]) < w_n_acc);
      w_deq_hit[i]  = (CNT_W'(w_deq_off[i]) < w_deq);
      w_enq_data[i] = '0;
      for (int k = 0; k < IN_WIDTH; k++) begin
        if (w_enq_off[i] == PTR_W'(k)) w_enq_data[i] = w_in_res[k];
      end
      w_mem_res[i] = fwd_resolve(r_mem[i], fwd_valid, fwd_tag, fwd_data);
    end
  end

  // Issue window: entries head .. head+OUT_WIDTH-1.
  always_comb begin
    out_entry = '0;
    out_ready = '0;
    for (int k = 0; k < OUT_WIDTH; k++) begin
      w_out_idx[k] = PTR_W'(r_head + PTR_W'(k));
      w_out_vld[k] = (CNT_W'(k) < r_count);
      out_entry[k*ENTRY_W +: ENTRY_W] = {w_out_vld[k], r_mem[w_out_idx[k]]};
      out_ready[k] = w_out_vld[k] & ~r_mem[w_out_idx[k]][PEND_A] & ~r_mem[w_out_idx[k]][PEND_B];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      r_head  <= PTR_W'(r_head + PTR_W'(w_deq));
      r_tail  <= PTR_W'(r_tail + PTR_W'(w_n_acc));
      r_count <= CNT_W'(r_count + w_n_acc - w_deq);
      r_valid <= (r_valid & ~w_deq_hit) | w_enq_hit;
    end
  end

  // Payload storage is not reset; validity is tracked by r_valid/r_count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_enq_hit[i]) begin
        r_mem[i] <= w_enq_data[i];
      end else if (r_valid[i] && !w_deq_hit[i]) begin
        r_mem[i] <= w_mem_res[i];
      end
    end
  end

endmodule

// File: doc/issue_queue_multi.md
Name: issue_queue_multi

Overview:
- Parametrised in-order issue queue that replaces the fixed 64-entry/4-in/2-out queue between rename/dispatch and the execution units.
- Accepts up to IN_WIDTH dispatched ops per cycle and presents the oldest OUT_WIDTH entries to issue.
- Snoops FWD_PORTS result buses to capture pending operands, including for ops being enqueued in the same cycle.
- Adds reset, flush, occupancy, backpressure (in_ready), per-lane operand-ready flags, and dequeue clamping.

Parameters:
DEPTH 64 number of entries; power of two, >= 4
IN_WIDTH 4 enqueue lanes per cycle
OUT_WIDTH 2 issue lanes presented per cycle
FWD_PORTS 4 result forwarding buses
OP_W 4 opcode width
TAG_W 6 ROB/tag width
DATA_W 16 operand width
(derived) PAY_W = OP_W+3*TAG_W+2*DATA_W+2; ENTRY_W = PAY_W+1; CNT_W = $clog2(DEPTH+1)

Ports:
clk input 1 clock, all state on rising edge
reset input 1 synchronous active-high reset
flush input 1 synchronous squash of all entries
in_valid input IN_WIDTH per-lane enqueue request; must be a contiguous prefix from lane 0
in_entry input IN_WIDTH*PAY_W lane k at [k*PAY_W +: PAY_W] = {op, rob, tagA, tagB, valA, valB, pendA, pendB}
in_ready output 1 high when count <= DEPTH-IN_WIDTH
fwd_valid input FWD_PORTS per-bus result valid
fwd_tag input FWD_PORTS*TAG_W result tag per bus
fwd_data input FWD_PORTS*DATA_W result value per bus
out_entry output OUT_WIDTH*ENTRY_W lane k = {valid, payload} of entry head+k
out_ready output OUT_WIDTH lane k valid and pendA==0 and pendB==0
deq_count input $clog2(OUT_WIDTH+1) number of head entries consumed this cycle
count output CNT_W current occupancy

Behaviour:
- Reset (synchronous, highest priority): head=tail=count=0, all valid bits cleared. Consequently in_ready=1, out_entry valid bits=0, out_ready=0. Enqueue, dequeue and forwarding are ignored in that cycle.
- Flush (next priority): same state effect as reset; enqueue and dequeue in the flush cycle are discarded. Payload RAM contents are don't-care.
- Circular buffer; indices wrap modulo DEPTH.
- Outputs are combinational from registered state:
  - out lane k shows entry (head+k) mod DEPTH, valid only if k < count.
  - Invalid lanes drive valid=0; the payload is don't-care.
- Dequeue:
  - effective deq = min(deq_count, number of valid output lanes).
  - head += deq; the dequeued valid bits are cleared.
  - The queue does not check out_ready; the issue logic consumes only ready lanes.
- Enqueue:
  - Accepted only if in_ready=1; when in_ready=0 all lanes are dropped.
  - n = popcount(in_valid). Lane k writes (tail+k) mod DEPTH; tail += n.
  - A non-prefix in_valid is a protocol violation; the bench asserts on it.
- in_ready uses the current count only; same-cycle dequeue is not credited.
- count_next = count + n_accepted - deq (no clamping needed given in_ready).
- Forwarding applies every cycle to every valid stored entry and to every accepted incoming lane:
  - If pendA and tagA == fwd_tag[p] with fwd_valid[p]: valA <= fwd_data[p], pendA <= 0. pendB/tagB/valB behave identically.
  - If multiple buses match the same operand, the lowest-index bus wins.
  - Incoming lanes are written already resolved, so no forward is lost at the dispatch/enqueue boundary.
  - Entries dequeued in the same cycle are not updated.
  - Forwarded values are visible on out_entry the cycle after capture (no combinational bypass to outputs).
- Full and empty:
  - Full (count=DEPTH): in_ready=0.
  - Empty: all out valid=0, and deq_count is ignored.
- Latency:
  - enqueue -> visible at out lane 0 one cycle later if the queue was empty;
  - forward -> out_ready rises one cycle later.

Test Plan:
- Reset mid-operation: fill 10 entries, assert reset one cycle -> next cycle count=0, in_ready=1, out valid bits=0; the enqueue offered during reset is absent.
- Wrap-around: DEPTH=8, IN_WIDTH=4; enqueue 4, deq 2 per cycle for 12 cycles -> rob order at lane 0 strictly sequential 0,1,2…, count never exceeds 8, head/tail wrap without loss.
- Backpressure: fill to count=5 (DEPTH=8) -> in_ready=0, a 4-lane enqueue is dropped, count stays 5; deq 1 -> in_ready=1 the following cycle.
- Same-cycle forward on enqueue: enqueue lane 0 with tagA=6'h12, pendA=1 while fwd_valid[2]=1, fwd_tag=6'h12, fwd_data=16'hBEEF -> next cycle lane 0 valA=16'hBEEF, out_ready[0]=1.
- Forward priority: stored entry tagB=6'h05 pending; fwd port0 {05, 16'h1111}, port3 {05, 16'h2222} same cycle -> valB=16'h1111.
- Flush with dequeue and enqueue: count=3, deq_count=2, 2-lane enqueue, flush=1 -> count=0 next cycle, out valid=0; a subsequent single enqueue appears at lane 0 one cycle later.
